// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point add/subtract (align, add/normalise, round/pack).
// Define FP_ADDSUB_INEXACT_EN to add the inx (inexact) output.
module fp_addsub_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op_sub,
  input  logic [EW+MW:0] x1,
  input  logic [EW+MW:0] x2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+MW:0] y,
`ifdef FP_ADDSUB_INEXACT_EN
  output logic           inx,
`endif
  output logic           ovf
);
  localparam int W = 1 + EW + MW;
  localparam int SH = MW + 3;
  localparam logic [EW-1:0] EMAX = '1;
  localparam logic [W-1:0] QB = W'(1) << (MW - 1);
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  logic sa, sb, nan1, nan2, inf1, inf2, swap, sg_c, sp_c;
  logic [W-1:0] spy_c;
  logic [W-2:0] mag_b, mag_s;
  logic [EW-1:0] eb, es;
  logic [31:0] dif, dsh;
  logic [2*SH-1:0] shv;
  always_comb begin
    sa = x1[W-1];
    sb = x2[W-1] ^ op_sub;
    nan1 = &x1[W-2:MW] && |x1[MW-1:0];
    nan2 = &x2[W-2:MW] && |x2[MW-1:0];
    inf1 = &x1[W-2:MW] && !(|x1[MW-1:0]);
    inf2 = &x2[W-2:MW] && !(|x2[MW-1:0]);
    swap = x2[W-2:0] > x1[W-2:0];
    mag_b = swap ? x2[W-2:0] : x1[W-2:0];
    mag_s = swap ? x1[W-2:0] : x2[W-2:0];
    sg_c = swap ? sb : sa;
    eb = |mag_b[W-2:MW] ? mag_b[W-2:MW] : EW'(1);
    es = |mag_s[W-2:MW] ? mag_s[W-2:MW] : EW'(1);
    dif = 32'(eb) - 32'(es);
    dsh = dif > 32'(SH) ? 32'(SH) : dif;
    shv = {|mag_s[W-2:MW], mag_s[MW-1:0], 2'b00, {SH{1'b0}}} >> dsh;
    sp_c = nan1 | nan2 | inf1 | inf2;
    spy_c = nan1 ? (x1 | QB) :
            nan2 ? (x2 | QB) :
            (inf1 && inf2) ? ((sa == sb) ? {sa, EMAX, {MW{1'b0}}} : {1'b1, EMAX, QB[MW-1:0]}) :
            inf1 ? {sa, EMAX, {MW{1'b0}}} : {sb, EMAX, {MW{1'b0}}};
  end
  logic v1, sp1, sg1, sub1, st1;
  logic [W-1:0] spy1;
  logic [EW-1:0] e1;
  logic [MW:0] ma1;
  logic [SH-1:0] mb1;
  logic [MW+4:0] r;
  logic [MW+3:0] nrm;
  logic [EW-1:0] ex_c;
  logic sg2_c;
  int lz, lim, nsh;
  // Left shift is clamped so the exponent never drops below 1; a missing hidden bit then means subnormal.
  always_comb begin
    r = sub1 ? {1'b0, ma1, 3'b000} - {1'b0, mb1, st1} : {1'b0, ma1, 3'b000} + {1'b0, mb1, st1};
    lz = MW + 4;
    for (int i = 0; i < MW + 4; i++) lz = r[i] ? MW + 3 - i : lz;
    lim = int'(e1) - 1;
    nsh = lz < lim ? lz : lim;
    nrm = r[MW+4] ? {r[MW+4:2], r[1] | r[0]} : r[MW+3:0] << nsh;
    ex_c = r[MW+4] ? e1 + 1'b1 : e1 - EW'(nsh);
    ex_c = nrm[MW+3] ? ex_c : '0;
    sg2_c = (r == '0 && sub1) ? 1'b0 : sg1;
  end
  logic v2, sp2, sg2;
  logic [W-1:0] spy2;
  logic [EW-1:0] ex2;
  logic [MW+2:0] n2;
  logic rup, ov_c, inx_c;
  logic [EW+MW-1:0] pk;
  logic [W-1:0] res;
  // Rounding adds into the packed {exp, mant} so mantissa carry bumps the exponent naturally.
  always_comb begin
    rup = n2[2] & (n2[3] | n2[1] | n2[0]);
    pk = {ex2, n2[MW+2:3]} + (EW+MW)'(rup);
    ov_c = !sp2 && (&ex2 || &pk[EW+MW-1:MW]);
    inx_c = !sp2 && (|n2[2:0] || ov_c);
    res = sp2 ? spy2 : ov_c ? {sg2, EMAX, {MW{1'b0}}} : {sg2, pk};
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0; sp1 <= 1'b0; spy1 <= '0; sg1 <= 1'b0; sub1 <= 1'b0;
      e1 <= '0; ma1 <= '0; mb1 <= '0; st1 <= 1'b0;
      v2 <= 1'b0; sp2 <= 1'b0; spy2 <= '0; sg2 <= 1'b0; ex2 <= '0; n2 <= '0;
      out_valid <= 1'b0; y <= '0; ovf <= 1'b0;
`ifdef FP_ADDSUB_INEXACT_EN
      inx <= 1'b0;
`endif
    end else if (adv) begin
      v1 <= in_valid; sp1 <= sp_c; spy1 <= spy_c; sg1 <= sg_c; sub1 <= sa ^ sb;
      e1 <= eb; ma1 <= {|mag_b[W-2:MW], mag_b[MW-1:0]};
      mb1 <= shv[2*SH-1:SH]; st1 <= |shv[SH-1:0];
      v2 <= v1; sp2 <= sp1; spy2 <= spy1; sg2 <= sg2_c; ex2 <= ex_c; n2 <= nrm[MW+2:0];
      out_valid <= v2; y <= res; ovf <= ov_c;
`ifdef FP_ADDSUB_INEXACT_EN
      inx <= inx_c;
`endif
    end
  end
`ifndef FP_ADDSUB_INEXACT_EN
  logic unused_inx;
  assign unused_inx = inx_c;
`endif
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed single-precision checks of fp_addsub_pipe.
module tb_fp_addsub_pipe;
  logic clk = 0, rstn = 0, in_valid = 0, in_ready, op_sub = 0, out_valid, out_ready = 1, ovf;
  logic [31:0] x1 = 0, x2 = 0, y;
`ifdef FP_ADDSUB_INEXACT_EN
  logic inx;
`endif
  int tests = 0, fails = 0;

  fp_addsub_pipe #(.EW(8), .MW(23)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready), .y(y),
`ifdef FP_ADDSUB_INEXACT_EN
    .inx(inx),
`endif
    .ovf(ovf));

  always #5 clk = ~clk;

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] ry, output logic rov, output int lat);
    @(posedge clk); #1;
    x1 = a; x2 = b; op_sub = s; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ry = y; rov = ovf;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (y !== 32'h0) begin fails++; $display("FAIL reset_y: got %h want 00000000", y); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rstn = 1;
  endtask

  task automatic test_vectors();
    logic [31:0] va [15] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800001,
                             32'h00000001, 32'h7F7FFFFF, 32'h7F800000, 32'h7FA00000, 32'h3F800000,
                             32'h7FC00001, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h80000000};
    logic [31:0] vb [15] = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h33800000, 32'h33800000,
                             32'h00000001, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'hFFA00000,
                             32'hFFC00000, 32'h7F800000, 32'h00000001, 32'h3FC00000, 32'h00000000};
    logic vs [15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] ve [15] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800002,
                             32'h00000002, 32'h7F800000, 32'hFFC00000, 32'h7FE00000, 32'hFFE00000,
                             32'h7FC00001, 32'hFF800000, 32'h3F800000, 32'hBF000000, 32'h80000000};
    logic vo [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ry;
    logic rov;
    int lat;
    for (int i = 0; i < 15; i++) begin
      run_op(va[i], vb[i], vs[i], ry, rov, lat);
      tests++; if (lat != 3) begin fails++; $display("FAIL vec%0d_latency: got %0d want 3", i, lat); end
      tests++; if (ry !== ve[i]) begin fails++; $display("FAIL vec%0d_y: got %h want %h", i, ry, ve[i]); end
      tests++; if (rov !== vo[i]) begin fails++; $display("FAIL vec%0d_ovf: got %b want %b", i, rov, vo[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ax [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40800000};
    logic [31:0] bx [5] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic sx [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ex [5] = '{32'h40400000, 32'h00000000, 32'h40000000, 32'h40800000, 32'h40A00000};
    int sent = 0, recv = 0, cyc = 0, extra = 0;
    logic stalled = 0;
    logic [31:0] held = 0;
    while (recv < 5 && cyc < 200) begin
      @(posedge clk); #1;
      out_ready = (cyc % 2 == 0);
      if (stalled) begin
        tests++; if (out_valid !== 1'b1 || y !== held) begin fails++; $display("FAIL b2b_stall_hold: got v=%b y=%h want v=1 y=%h", out_valid, y, held); end
      end
      in_valid = (sent < 5);
      if (sent < 5) begin x1 = ax[sent]; x2 = bx[sent]; op_sub = sx[sent]; end
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        tests++; if (y !== ex[recv]) begin fails++; $display("FAIL b2b_result%0d: got %h want %h", recv, y, ex[recv]); end
        recv++;
      end
      stalled = out_valid && !out_ready;
      held = y;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    tests++; if (recv != 5) begin fails++; $display("FAIL b2b_count: got %0d want 5", recv); end
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL b2b_duplicate: got %0d extra want 0", extra); end
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    logic [31:0] ry;
    logic rov;
    int lat;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; x1 = 32'h3F800000; x2 = 32'h40000000; op_sub = 0;
    @(posedge clk); #1;
    x1 = 32'h40000000; x2 = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || y !== 32'h40400000) begin fails++; $display("FAIL inflight_stalled: got v=%b y=%h want v=1 y=40400000", out_valid, y); end
    rstn = 0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL inflight_reset_valid: got %b want 0", out_valid); end
    tests++; if (y !== 32'h0 || ovf !== 1'b0) begin fails++; $display("FAIL inflight_reset_y: got y=%h ovf=%b want 0/0", y, ovf); end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1; out_ready = 1;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL inflight_emitted: got %0d outputs want 0", seen); end
    run_op(32'h40400000, 32'h3F800000, 1'b1, ry, rov, lat);
    tests++; if (ry !== 32'h40000000 || lat != 3) begin fails++; $display("FAIL post_reset_op: got y=%h lat=%0d want 40000000/3", ry, lat); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point adder/subtractor. It is the next-generation replacement for the combinational single-precision subtract unit in the FPU.
- Exponent and mantissa widths are generic. A per-operation op bit selects add or subtract.
- Valid/ready handshakes on both sides let it sit between the CPU issue stage and writeback with backpressure.
- Fixed 3-stage pipeline: align, add/normalise, round/pack.

Parameters:
- EW, 8, exponent field width (≥3).
- MW, 23, stored mantissa field width (≥2); word width W = 1+EW+MW.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/op present.
- in_ready  output  1  unit accepts the operands this cycle.
- op_sub  input  1  0: y = x1 + x2; 1: y = x1 - x2 (x2 sign inverted).
- x1  input  W  operand 1.
- x2  input  W  operand 2.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- y  output  W  result.
- ovf  output  1  finite operands produced ±inf (overflow); valid with y.

Behaviour:
- Reset (rstn low, asynchronous): all stage valid bits 0, out_valid 0, y 0, ovf 0. Any in-flight operations are discarded, never emitted. The first acceptance is allowed on the first clock edge after rstn deasserts.
- Advance: adv = !out_valid || out_ready. in_ready = adv, and is purely combinational from out_valid/out_ready.
- Transfer: accepted when in_valid && in_ready; emitted when out_valid && out_ready.
- When adv = 1, every stage shifts one place; stage-1 valid takes in_valid.
- When adv = 0, every stage, y, ovf and out_valid hold.
- Bubbles are carried as invalid stages.
- Latency is exactly 3 clocks from acceptance to out_valid with out_ready held high. Throughput is 1 per clock.
- Ordering is strictly in order. y/ovf are stable while out_valid && !out_ready.
- Stage 1 (align):
  - Unpack the operands. Subnormals (exp = 0) use effective exponent 1 and hidden bit 0.
  - Swap so the larger magnitude is first. On equal exponents, compare mantissas; on full equality the first operand stays first.
  - Right-shift the smaller operand by the exponent difference, saturated at MW+3. Keep guard, round and a sticky OR of all shifted-out bits.
- Stage 2 (add/normalise):
  - Effective subtract = sign1 XOR sign2 XOR op_sub. Add or subtract the magnitudes into an (MW+5)-bit result.
  - On carry-out: shift right 1, increment the exponent, OR the dropped bit into sticky.
  - Otherwise: left-normalise by the leading-zero count. Clamp the shift so the exponent does not go below 1; a clamped result is subnormal (exp field 0).
- Stage 3 (round/pack):
  - Round to nearest, ties to even.
  - If rounding carries out of the mantissa, increment the exponent and zero the mantissa.
  - A subnormal that rounds up to the hidden bit becomes the minimum normal.
  - Exponent reaching all-ones gives ±inf with mantissa 0 and ovf = 1.
- Zero result: exact cancellation gives +0. (-0) + (-0) gives -0, including the op_sub-adjusted signs.
- Special cases take priority over arithmetic and never set ovf:
  - Either operand NaN: return that NaN with the quiet bit (mantissa MSB) forced to 1. If both are NaN, x1 wins. The sign of a propagated x2 NaN is not inverted.
  - inf ± finite: the inf with its effective sign.
  - inf + inf of the same effective sign: that inf.
  - inf - inf: canonical NaN = sign 1, exp all-ones, mantissa MSB 1, rest 0.
- ovf applies only when neither operand is inf or NaN.

Optional Feature:
- Macro: FP_ADDSUB_INEXACT_EN.
- When defined:
  - Adds output port inx (1 bit, reset 0), valid with y and held under stall.
  - inx = 1 when guard|round|sticky was nonzero before rounding, or when ovf = 1.
  - inx = 0 for all special-case results.
- When undefined: the inx port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic add, EW=8/MW=23: x1=0x3F800000, x2=0x40000000, op_sub=0 -> y=0x40400000, ovf=0, out_valid exactly 3 clocks after acceptance.
- Cancellation and zero sign:
  - 0x3F800000 - 0x3F800000 -> 0x00000000.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
  - 0x3F800001 + 0x33800000 -> 0x3F800002.
- Subnormal and overflow:
  - 0x00000001 + 0x00000001 -> 0x00000002.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, ovf=1.
- Specials:
  - 0x7F800000 - 0x7F800000 -> 0xFFC00000, ovf=0.
  - 0x7FA00000 + 1.0 -> 0x7FE00000.
- Backpressure and reset:
  - Stream 5 back-to-back ops with out_ready toggling 1/0 every cycle -> results in order, no loss or duplication, y stable while stalled.
  - Assert rstn low with 2 ops in flight -> out_valid=0 immediately, neither op emitted after release.
